mem_stage: RTL and testbench



---
 rtl/mem_stage_if.sv | 35 +++
 rtl/mem_stage.sv | 132 +++++++++++++
 tb/tb_mem_stage.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// mem_stage pipeline interface: exe->mem, mem->wb handshakes,
// feedback buses and data SRAM read response.
interface mem_stage_if #(
  parameter int ES_TO_MS_BUS_WD = 77,
  parameter int MS_TO_WS_BUS_WD = 76,
  parameter int MS_TO_DS_BUS_WD = 39
);
  logic                       es_to_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic                       ms_allowin;
  logic                       ws_allowin;
  logic                       ws_flush;
  logic                       ms_to_ws_valid;
  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
  logic                       ms_to_es_bus;
  logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus;
  logic                       data_sram_rvalid;
  logic [31:0]                data_sram_rdata;

  modport slave (
    input  es_to_ms_valid, es_to_ms_bus,
    input  ws_allowin, ws_flush,
    input  data_sram_rvalid, data_sram_rdata,
    output ms_allowin, ms_to_ws_valid, ms_to_ws_bus,
    output ms_to_es_bus, ms_to_ds_bus
  );

  modport master (
    output es_to_ms_valid, es_to_ms_bus,
    output ws_allowin, ws_flush,
    output data_sram_rvalid, data_sram_rdata,
    input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus,
    input  ms_to_es_bus, ms_to_ds_bus
  );
endinterface

// File: rtl/mem_stage.sv
// MIPS memory-access stage: registers exe bus, waits for load data,
// buffers it under wb backpressure, drains orphaned reads after flush.
module mem_stage (
  input logic        clk,
  input logic        resetn,
  mem_stage_if.slave ms
);
  localparam int ES_WD = 77;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             ms_valid;
  logic [ES_WD-1:0] bus_r;
  logic [31:0]      hold_r;

  logic        r_ex;
  logic [4:0]  r_excode;
  logic        r_rfm;
  logic        r_gr_we;
  logic [4:0]  r_dest;
  logic [31:0] r_alu;
  logic [31:0] r_pc;

  assign {r_ex, r_excode, r_rfm, r_gr_we,
          r_dest, r_alu, r_pc} = bus_r;

  logic ms_ready_go;
  logic allowin;
  logic capture;
  logic need_data;
  logic is_load;
  logic rvalid;
  logic flush;
  logic [31:0] final_result;
  logic fwd_we;
  logic fwd_stall;

  assign rvalid  = ms.data_sram_rvalid;
  assign flush   = ms.ws_flush;
  assign is_load = r_rfm & ~r_ex;

  assign ms_ready_go = ~is_load
                     | (state == HOLD)
                     | ((state == WAIT) & rvalid);

  assign allowin = (state != DRAIN)
                 & (~ms_valid | (ms_ready_go & ms.ws_allowin));

  assign capture   = ms.es_to_ms_valid & allowin & ~flush;
  assign need_data = capture
                   & ms.es_to_ms_bus[70]
                   & ~ms.es_to_ms_bus[76];

  // Loads take SRAM data live in WAIT, buffered data in HOLD.
  always_comb begin
    final_result = r_alu;
    if (is_load)
      final_result = (state == HOLD) ? hold_r
                                     : ms.data_sram_rdata;
  end

  assign fwd_we    = ms_valid & r_gr_we & ~r_ex
                   & (r_dest != 5'd0);
  assign fwd_stall = fwd_we & r_rfm & ~ms_ready_go;

  assign ms.ms_allowin     = allowin;
  assign ms.ms_to_ws_valid = ms_valid & ms_ready_go & ~flush;
  assign ms.ms_to_ws_bus   = {r_ex, r_excode, r_gr_we, r_dest,
                              final_result, r_pc};
  assign ms.ms_to_es_bus   = ms_valid & r_ex;
  assign ms.ms_to_ds_bus   = {fwd_we, fwd_stall, r_dest,
                              final_result};

  // Load-response FSM next state; flush always beats capture.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (need_data) state_nxt = WAIT;
      WAIT:
        if (flush)
          state_nxt = rvalid ? IDLE : DRAIN;
        else if (rvalid)
          state_nxt = ms.ws_allowin
                    ? (need_data ? WAIT : IDLE)
                    : HOLD;
      HOLD:
        if (flush)
          state_nxt = IDLE;
        else if (ms.ws_allowin)
          state_nxt = need_data ? WAIT : IDLE;
      DRAIN:
        if (rvalid) state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Stage valid bit: flush kills, otherwise refill on allowin.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)    ms_valid <= 1'b0;
    else if (flush) ms_valid <= 1'b0;
    else if (allowin)
      ms_valid <= ms.es_to_ms_valid;
  end

  // Payload register from exe_stage.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)      bus_r <= '0;
    else if (capture) bus_r <= ms.es_to_ms_bus;
  end

  // Buffer load data that arrives while wb_stage stalls.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      hold_r <= '0;
    else if ((state == WAIT) & rvalid
             & ~ms.ws_allowin & ~flush)
      hold_r <= ms.data_sram_rdata;
  end
endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
// Inputs change 1ns after posedge; outputs sampled 1ns later.
module tb_mem_stage;
  logic clk = 1'b0;
  logic resetn;
  int   n_chk  = 0;
  int   n_fail = 0;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  always #5 clk = ~clk;

  mem_stage_if bus ();

  mem_stage dut (
    .clk   (clk),
    .resetn(resetn),
    .ms    (bus)
  );

  logic        o_ex;
  logic [4:0]  o_code;
  logic [31:0] o_res;
  logic [31:0] o_pc;
  logic        f_we;
  logic        f_stall;
  logic [31:0] f_data;
  logic [1:0]  st;

  assign o_ex    = bus.ms_to_ws_bus[75];
  assign o_code  = bus.ms_to_ws_bus[74:70];
  assign o_res   = bus.ms_to_ws_bus[63:32];
  assign o_pc    = bus.ms_to_ws_bus[31:0];
  assign f_we    = bus.ms_to_ds_bus[38];
  assign f_stall = bus.ms_to_ds_bus[37];
  assign f_data  = bus.ms_to_ds_bus[31:0];
  assign st      = dut.state;

  function automatic logic [76:0] mk(
    input logic ex, input logic [4:0] code,
    input logic rfm, input logic we,
    input logic [4:0] dest, input logic [31:0] alu,
    input logic [31:0] pc);
    return {ex, code, rfm, we, dest, alu, pc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.es_to_ms_valid   = 1'b0;
    bus.es_to_ms_bus     = '0;
    bus.ws_allowin       = 1'b1;
    bus.ws_flush         = 1'b0;
    bus.data_sram_rvalid = 1'b0;
    bus.data_sram_rdata  = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 1'b0;
    settle();
    n_chk++;
    if (bus.ms_to_ws_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid got %b exp 0",
               bus.ms_to_ws_valid);
    end
    n_chk++;
    if (bus.ms_allowin !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_allowin got %b exp 1",
               bus.ms_allowin);
    end
    n_chk++;
    if (bus.ms_to_es_bus !== 1'b0 || f_we !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_es_fwd got %b/%b exp 0/0",
               bus.ms_to_es_bus, f_we);
    end
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_alu();
    bus.es_to_ms_valid = 1'b1;
    bus.es_to_ms_bus = mk(0, 0, 0, 1, 5'd3, 32'h12, 32'h100);
    settle();
    n_chk++;
    if (bus.ms_allowin !== 1'b1) begin
      n_fail++;
      $display("FAIL alu_allowin got %b exp 1", bus.ms_allowin);
    end
    tick();
    bus.es_to_ms_valid = 1'b0;
    settle();
    n_chk++;
    if (bus.ms_to_ws_valid !== 1'b1 || o_res !== 32'h12
        || o_pc !== 32'h100) begin
      n_fail++;
      $display("FAIL alu_out got v=%b r=%h pc=%h exp 1/12/100",
               bus.ms_to_ws_valid, o_res, o_pc);
    end
    n_chk++;
    if (f_we !== 1'b1 || f_stall !== 1'b0
        || f_data !== 32'h12) begin
      n_fail++;
      $display("FAIL alu_fwd got we=%b st=%b d=%h exp 1/0/12",
               f_we, f_stall, f_data);
    end
    tick();
    n_chk++;
    if (bus.ms_to_ws_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_drain got %b exp 0",
               bus.ms_to_ws_valid);
    end
  endtask

  task automatic test_load_wait();
    bus.es_to_ms_valid = 1'b1;
    bus.es_to_ms_bus = mk(0, 0, 1, 1, 5'd4, 32'h2000, 32'h104);
    tick();
    bus.es_to_ms_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      n_chk++;
      if (f_stall !== 1'b1 || bus.ms_to_ws_valid !== 1'b0
          || bus.ms_allowin !== 1'b0) begin
        n_fail++;
        $display("FAIL lw_wait%0d got st=%b v=%b a=%b exp 1/0/0",
                 i, f_stall, bus.ms_to_ws_valid, bus.ms_allowin);
      end
      tick();
    end
    bus.data_sram_rvalid = 1'b1;
    bus.data_sram_rdata  = 32'hDEADBEEF;
    settle();
    n_chk++;
    if (bus.ms_to_ws_valid !== 1'b1 || o_res !== 32'hDEADBEEF
        || f_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL lw_data got v=%b r=%h st=%b exp 1/deadbeef/0",
               bus.ms_to_ws_valid, o_res, f_stall);
    end
    tick();
    bus.data_sram_rvalid = 1'b0;
    bus.data_sram_rdata  = 32'h0;
    settle();
    n_chk++;
    if (st !== S_IDLE || bus.ms_to_ws_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lw_idle got st=%0d v=%b exp 0/0",
               st, bus.ms_to_ws_valid);
    end
  endtask

  task automatic test_load_hold();
    bus.es_to_ms_valid = 1'b1;
    bus.es_to_ms_bus = mk(0, 0, 1, 1, 5'd5, 32'h3000, 32'h108);
    tick();
    bus.es_to_ms_valid   = 1'b0;
    bus.ws_allowin       = 1'b0;
    bus.data_sram_rvalid = 1'b1;
    bus.data_sram_rdata  = 32'hDEADBEEF;
    tick();
    bus.data_sram_rvalid = 1'b0;
    bus.data_sram_rdata  = 32'h11111111;
    for (int i = 0; i < 2; i++) begin
      settle();
      n_chk++;
      if (st !== S_HOLD || bus.ms_allowin !== 1'b0
          || o_res !== 32'hDEADBEEF) begin
        n_fail++;
        $display("FAIL hold%0d got st=%0d a=%b r=%h exp 2/0/deadbeef",
                 i, st, bus.ms_allowin, o_res);
      end
      tick();
    end
    bus.ws_allowin = 1'b1;
    settle();
    n_chk++;
    if (bus.ms_to_ws_valid !== 1'b1 || o_res !== 32'hDEADBEEF
        || bus.ms_allowin !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_rel got v=%b r=%h a=%b exp 1/deadbeef/1",
               bus.ms_to_ws_valid, o_res, bus.ms_allowin);
    end
    tick();
    n_chk++;
    if (st !== S_IDLE) begin
      n_fail++;
      $display("FAIL hold_idle got %0d exp 0", st);
    end
  endtask

  task automatic test_back_to_back();
    bus.es_to_ms_valid = 1'b1;
    bus.es_to_ms_bus = mk(0, 0, 1, 1, 5'd6, 32'h4000, 32'h10c);
    tick();
    bus.es_to_ms_bus = mk(0, 0, 1, 1, 5'd7, 32'h4004, 32'h110);
    bus.data_sram_rvalid = 1'b1;
    bus.data_sram_rdata  = 32'hA5A5A5A5;
    settle();
    n_chk++;
    if (o_res !== 32'hA5A5A5A5 || bus.ms_allowin !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first got r=%h a=%b exp a5a5a5a5/1",
               o_res, bus.ms_allowin);
    end
    tick();
    bus.es_to_ms_valid   = 1'b0;
    bus.data_sram_rvalid = 1'b0;
    settle();
    n_chk++;
    if (st !== S_WAIT || f_stall !== 1'b1
        || o_pc !== 32'h110) begin
      n_fail++;
      $display("FAIL b2b_wait got st=%0d s=%b pc=%h exp 1/1/110",
               st, f_stall, o_pc);
    end
    tick();
    bus.data_sram_rvalid = 1'b1;
    bus.data_sram_rdata  = 32'h5A5A0001;
    settle();
    n_chk++;
    if (bus.ms_to_ws_valid !== 1'b1 || o_res !== 32'h5A5A0001) begin
      n_fail++;
      $display("FAIL b2b_second got v=%b r=%h exp 1/5a5a0001",
               bus.ms_to_ws_valid, o_res);
    end
    tick();
    bus.data_sram_rvalid = 1'b0;
  endtask

  task automatic test_flush_drain();
    bus.es_to_ms_valid = 1'b1;
    bus.es_to_ms_bus = mk(0, 0, 1, 1, 5'd8, 32'h5000, 32'h114);
    tick();
    bus.es_to_ms_bus = mk(0, 0, 0, 1, 5'd9, 32'h77, 32'h118);
    bus.ws_flush = 1'b1;
    settle();
    n_chk++;
    if (bus.ms_to_ws_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fl_valid got %b exp 0", bus.ms_to_ws_valid);
    end
    tick();
    bus.ws_flush = 1'b0;
    settle();
    n_chk++;
    if (st !== S_DRAIN || bus.ms_allowin !== 1'b0
        || f_we !== 1'b0) begin
      n_fail++;
      $display("FAIL fl_drain got st=%0d a=%b we=%b exp 3/0/0",
               st, bus.ms_allowin, f_we);
    end
    tick();
    bus.es_to_ms_valid   = 1'b0;
    bus.data_sram_rvalid = 1'b1;
    bus.data_sram_rdata  = 32'hBAD0BAD0;
    settle();
    n_chk++;
    if (bus.ms_allowin !== 1'b0 || bus.ms_to_ws_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fl_rv got a=%b v=%b exp 0/0",
               bus.ms_allowin, bus.ms_to_ws_valid);
    end
    tick();
    bus.data_sram_rvalid = 1'b0;
    settle();
    n_chk++;
    if (st !== S_IDLE || bus.ms_allowin !== 1'b1
        || bus.ms_to_ws_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fl_idle got st=%0d a=%b v=%b exp 0/1/0",
               st, bus.ms_allowin, bus.ms_to_ws_valid);
    end
  endtask

  task automatic test_exception();
    bus.es_to_ms_valid = 1'b1;
    bus.es_to_ms_bus = mk(1, 5'h0c, 1, 1, 5'd10, 32'h6000, 32'h11c);
    bus.ws_allowin = 1'b0;
    tick();
    bus.es_to_ms_valid = 1'b0;
    settle();
    n_chk++;
    if (bus.ms_to_es_bus !== 1'b1 || bus.ms_to_ws_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ex_es got es=%b v=%b exp 1/1",
               bus.ms_to_es_bus, bus.ms_to_ws_valid);
    end
    n_chk++;
    if (o_ex !== 1'b1 || o_code !== 5'h0c || f_we !== 1'b0
        || st !== S_IDLE) begin
      n_fail++;
      $display("FAIL ex_out got ex=%b c=%h we=%b st=%0d exp 1/0c/0/0",
               o_ex, o_code, f_we, st);
    end
    tick();
    n_chk++;
    if (bus.ms_to_es_bus !== 1'b1) begin
      n_fail++;
      $display("FAIL ex_held got %b exp 1", bus.ms_to_es_bus);
    end
    bus.ws_allowin = 1'b1;
    tick();
    n_chk++;
    if (bus.ms_to_es_bus !== 1'b0) begin
      n_fail++;
      $display("FAIL ex_gone got %b exp 0", bus.ms_to_es_bus);
    end
  endtask

  task automatic test_flush_capture();
    bus.es_to_ms_valid = 1'b1;
    bus.es_to_ms_bus = mk(0, 0, 1, 1, 5'd11, 32'h7000, 32'h120);
    bus.ws_flush = 1'b1;
    tick();
    bus.es_to_ms_valid = 1'b0;
    bus.ws_flush = 1'b0;
    settle();
    n_chk++;
    if (st !== S_IDLE || bus.ms_to_ws_valid !== 1'b0
        || f_we !== 1'b0) begin
      n_fail++;
      $display("FAIL flcap got st=%0d v=%b we=%b exp 0/0/0",
               st, bus.ms_to_ws_valid, f_we);
    end
  endtask

  task automatic test_async_reset();
    bus.es_to_ms_valid = 1'b1;
    bus.es_to_ms_bus = mk(0, 0, 1, 1, 5'd12, 32'h8000, 32'h124);
    tick();
    bus.es_to_ms_valid = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    n_chk++;
    if (st !== S_IDLE || f_stall !== 1'b0 || f_we !== 1'b0
        || bus.ms_allowin !== 1'b1) begin
      n_fail++;
      $display("FAIL arst got st=%0d s=%b we=%b a=%b exp 0/0/0/1",
               st, f_stall, f_we, bus.ms_allowin);
    end
    tick();
    resetn = 1'b1;
    tick();
    n_chk++;
    if (st !== S_IDLE || bus.ms_allowin !== 1'b1
        || bus.ms_to_ws_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_rel got st=%0d a=%b v=%b exp 0/1/0",
               st, bus.ms_allowin, bus.ms_to_ws_valid);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_load_hold();
    test_back_to_back();
    test_flush_drain();
    test_exception();
    test_flush_capture();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
